serial_display_ctrl: RTL and testbench

Parametrised serial display controller: drives a MAX7219-style 7-segment driver over a 3-wire bus (LOAD, DOUT, SCK) for 1–8 digits. It runs the driver initialisation sequence automatically, then rewrites brightness and all digits on each update request, coalescing requests that arrive mid-transfer. It sits between the time-keeping and BCD formatting logic and the `uio_out[0]`, `uio_out[1]` and `uio_out[3]` pins of the top level. It replaces the fixed 6-digit serial path.

---
 rtl/display_pkg.sv | 35 +++
 rtl/serial_word_tx.sv | 121 ++++++++++++
 rtl/serial_display_ctrl.sv | 170 +++++++++++++++++
 tb/tb_serial_display_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants and state types for the serial 7-segment display path.
// Register addresses follow the MAX7219 register map.
package display_pkg;

  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_REFRESH
  } ctrl_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_SETUP,
    W_HIGH,
    W_LOW,
    W_GAP
  } word_state_e;

  // Builds a 16-bit driver word from register address and data byte.
  function automatic logic [15:0] mk_word(
    input logic [3:0] addr,
    input logic [7:0] data
  );
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/serial_word_tx.sv
// 16-bit MSB-first word engine for the LOAD/DOUT/SCK bus.
// Each phase lasts CLK_DIV cycles; a word is 34 phases long.
module serial_word_tx
  import display_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [15:0] i_word,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_serial_load,
  output logic        o_serial_dout,
  output logic        o_serial_clk
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  word_state_e st_q, st_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic load_q, load_d;
  logic sck_q, sck_d;
  logic dout_q, dout_d;
  logic tick;
  logic launch;

  assign tick = (div_q == DIV_MAX);
  assign o_ready = (st_q == W_IDLE) ||
                   ((st_q == W_GAP) && tick);
  assign o_serial_load = load_q;
  assign o_serial_dout = dout_q;
  assign o_serial_clk  = sck_q;

  // Engine and bus output registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      st_q   <= W_IDLE;
      div_q  <= '0;
      bit_q  <= 4'd0;
      sh_q   <= 16'h0;
      load_q <= 1'b1;
      sck_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      load_q <= load_d;
      sck_q  <= sck_d;
      dout_q <= dout_d;
    end
  end

  // Phase sequencing; a start at the end of GAP chains words back-to-back.
  always_comb begin
    st_d   = st_q;
    div_d  = div_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    load_d = load_q;
    sck_d  = sck_q;
    dout_d = dout_q;
    o_done = 1'b0;
    launch = 1'b0;
    if (st_q != W_IDLE)
      div_d = tick ? '0 : div_q + DW'(1);
    unique case (st_q)
      W_IDLE: launch = i_start;
      W_SETUP: begin
        if (tick) begin
          st_d  = W_HIGH;
          sck_d = 1'b1;
        end
      end
      W_HIGH: begin
        if (tick) begin
          st_d  = W_LOW;
          sck_d = 1'b0;
          if (bit_q != 4'd0)
            dout_d = sh_q[bit_q - 4'd1];
        end
      end
      W_LOW: begin
        if (tick) begin
          if (bit_q == 4'd0) begin
            st_d   = W_GAP;
            load_d = 1'b1;
            dout_d = 1'b0;
          end else begin
            st_d  = W_HIGH;
            bit_d = bit_q - 4'd1;
            sck_d = 1'b1;
          end
        end
      end
      W_GAP: begin
        if (tick) begin
          o_done = 1'b1;
          st_d   = W_IDLE;
          launch = i_start;
        end
      end
      default: st_d = W_IDLE;
    endcase
    if (launch) begin
      st_d   = W_SETUP;
      div_d  = '0;
      sh_d   = i_word;
      bit_d  = 4'd15;
      load_d = 1'b0;
      dout_d = i_word[15];
    end
  end

endmodule

// File: rtl/serial_display_ctrl.sv
// MAX7219-style display controller: init sequence, then coalesced refreshes.
// Option SERIAL_DISPLAY_LEADING_BLANK_EN blanks leading zero digits.
module serial_display_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_DIV    = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_en,
  input  logic                    i_update,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [3:0]              i_brightness,
  output logic                    o_serial_load,
  output logic                    o_serial_dout,
  output logic                    o_serial_clk,
  output logic                    o_busy
);

  localparam logic [3:0] N_INIT = 4'd5;
  localparam logic [3:0] N_REF  = 4'(NUM_DIGITS + 1);
  localparam logic [3:0] SCAN   = 4'(NUM_DIGITS - 1);

  ctrl_state_e st_q, st_d;
  logic [3:0] idx_q, idx_d;
  logic pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [3:0] bri_q, bri_d;

  logic eng_ready;
  logic eng_done;
  logic start;
  logic more;
  logic seq_end;
  logic enter_ref;
  logic [3:0] nwords;
  logic [15:0] word;
  logic [3:0] bcd;
  logic [NUM_DIGITS-1:0] blank;

  serial_word_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_start      (start),
    .i_word       (word),
    .o_ready      (eng_ready),
    .o_done       (eng_done),
    .o_serial_load(o_serial_load),
    .o_serial_dout(o_serial_dout),
    .o_serial_clk (o_serial_clk)
  );

  assign o_busy = (st_q != ST_IDLE) || pend_q;

`ifdef SERIAL_DISPLAY_LEADING_BLANK_EN
  logic lead;

  // Blank zero digits from the top down until the first non-zero one.
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (lead && (dig_q[4*k +: 4] == 4'h0))
        blank[k] = 1'b1;
      else
        lead = 1'b0;
    end
  end
`else
  assign blank = '0;
`endif

  // Control state and latched display snapshot.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      st_q   <= ST_INIT;
      idx_q  <= 4'd0;
      pend_q <= 1'b0;
      dig_q  <= '0;
      dp_q   <= '0;
      bri_q  <= 4'h0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      dig_q  <= dig_d;
      dp_q   <= dp_d;
      bri_q  <= bri_d;
    end
  end

  // Word selection for the next word to launch.
  always_comb begin
    word = 16'h0;
    bcd  = 4'h0;
    if (st_q == ST_INIT) begin
      unique case (idx_q)
        4'd0:    word = mk_word(ADDR_SHUTDOWN, 8'h01);
        4'd1:    word = mk_word(ADDR_SCANLIM, {4'h0, SCAN});
        4'd2:    word = mk_word(ADDR_DECODE, 8'hFF);
        4'd3:    word = mk_word(ADDR_INTENSITY,
                                {4'h0, i_brightness});
        default: word = mk_word(ADDR_TEST, 8'h00);
      endcase
    end else if (idx_q == 4'd0) begin
      word = mk_word(ADDR_INTENSITY, {4'h0, bri_q});
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == 4'(k + 1)) begin
          bcd  = blank[k] ? BCD_BLANK : dig_q[4*k +: 4];
          word = mk_word(4'(k + 1),
                         {dp_q[k], 3'b000, bcd});
        end
      end
    end
  end

  // Sequencer: launches words, coalesces requests, chains refreshes.
  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    dig_d     = dig_q;
    dp_d      = dp_q;
    bri_d     = bri_q;
    enter_ref = 1'b0;
    nwords    = (st_q == ST_INIT) ? N_INIT : N_REF;
    more      = (idx_q < nwords);
    start     = (st_q != ST_IDLE) && i_en &&
                eng_ready && more;
    seq_end   = (st_q != ST_IDLE) && eng_done && !more;
    if (start)
      idx_d = idx_q + 4'd1;
    unique case (st_q)
      ST_INIT: begin
        if (seq_end)
          enter_ref = 1'b1;
      end
      ST_REFRESH: begin
        if (seq_end) begin
          if (pend_q)
            enter_ref = 1'b1;
          else
            st_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_en && (i_update || pend_q))
          enter_ref = 1'b1;
      end
      default: st_d = ST_INIT;
    endcase
    if (i_update)
      pend_d = 1'b1;
    if (enter_ref) begin
      st_d   = ST_REFRESH;
      idx_d  = 4'd0;
      pend_d = 1'b0;
      dig_d  = i_digits;
      dp_d   = i_dp;
      bri_d  = i_brightness;
    end
  end

endmodule

// File: tb/tb_serial_display_ctrl.sv
// Directed bench for serial_display_ctrl (NUM_DIGITS=6, CLK_DIV=2).
// A bus monitor decodes words; the main sequence checks them.
module tb_serial_display_ctrl;

  localparam int ND = 6;
  localparam int CD = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic upd;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp;
  logic [3:0] bri;
  logic load;
  logic dout;
  logic sck;
  logic busy;

  int nvec = 0;
  int nerr = 0;
  int m_err = 0;
  logic [15:0] wq[$];
  int gq[$];
  logic [15:0] ex[$];

  logic p_load = 1'b1;
  logic p_sck = 1'b0;
  int m_bits = 0;
  int m_low = 0;
  int m_hi = 0;
  int m_lo = 0;
  int m_gap = 0;
  bit m_seen = 1'b0;
  bit m_rose = 1'b0;
  logic [15:0] m_sh = 16'h0;

  always #5 clk = ~clk;

  serial_display_ctrl #(
    .NUM_DIGITS(ND),
    .CLK_DIV   (CD)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_en         (en),
    .i_update     (upd),
    .i_digits     (digits),
    .i_dp         (dp),
    .i_brightness (bri),
    .o_serial_load(load),
    .o_serial_dout(dout),
    .o_serial_clk (sck),
    .o_busy       (busy)
  );

  // Bus monitor: decodes words and tracks phase lengths.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_load = 1'b1;
      p_sck  = 1'b0;
      m_bits = 0;
      m_low  = 0;
      m_hi   = 0;
      m_lo   = 0;
      m_gap  = 0;
      m_seen = 1'b0;
      m_rose = 1'b0;
      m_sh   = 16'h0;
    end else begin
      if (load !== p_load && (sck || p_sck))
        m_err++;
      if (!load && p_load) begin
        if (m_rose) gq.push_back(m_gap);
        m_bits = 0;
        m_low  = 0;
        m_seen = 1'b0;
        m_sh   = 16'h0;
      end
      if (!load) m_low++;
      else m_gap++;
      if (sck && !p_sck) begin
        if (load) m_err++;
        if (m_seen && m_lo != CD) m_err++;
        m_sh = {m_sh[14:0], dout};
        m_bits++;
        m_hi = 1;
      end else if (sck) begin
        m_hi++;
      end
      if (!sck && p_sck) begin
        if (m_hi != CD) m_err++;
        m_lo = 1;
        m_seen = 1'b1;
      end else if (!sck) begin
        m_lo++;
      end
      if (load && !p_load) begin
        if (m_bits != 16) m_err++;
        if (m_low != 33 * CD) m_err++;
        wq.push_back(m_sh);
        m_gap = 1;
        m_rose = 1'b1;
      end
      p_load = load;
      p_sck  = sck;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  task automatic chk_words(input string tag, input int base);
    logic [31:0] got;
    foreach (ex[i]) begin
      got = (base + i < wq.size()) ?
            32'(wq[base + i]) : 32'hDEAD_BEEF;
      chk($sformatf("%s[%0d]", tag, i), got, 32'(ex[i]));
    end
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (wq.size() < n && c < 4000) begin
      step();
      c++;
    end
    chk("wait_words", wq.size(), n);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 4000) begin
      step();
      c++;
    end
    chk1("wait_idle", busy, 1'b0);
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    step();
    upd = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n  = 1'b0;
    en     = 1'b1;
    upd    = 1'b0;
    bri    = 4'h7;
    digits = 24'h123456;
    dp     = 6'b000100;
    repeat (3) step();
    chk1("rst_load", load, 1'b1);
    chk1("rst_sck", sck, 1'b0);
    chk1("rst_dout", dout, 1'b0);
    chk1("rst_busy", busy, 1'b1);

    // Boot: init words then automatic refresh.
    rst_n = 1'b1;
    wait_words(12);
    ex = '{16'h0C01, 16'h0B05, 16'h09FF,
           16'h0A07, 16'h0F00};
    chk_words("init", 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("init_gap[%0d]", i),
          (i < gq.size()) ? gq[i] : -1, CD);
    ex = '{16'h0A07, 16'h0106, 16'h0205, 16'h0384,
           16'h0403, 16'h0502, 16'h0601};
    chk_words("boot_ref", 5);
    wait_idle();

    // Single update from idle: latency and busy length.
    wq.delete();
    upd = 1'b1;
    step();
    upd = 1'b0;
    chk1("lat_c1_load", load, 1'b1);
    step();
    chk1("lat_c2_load", load, 1'b0);
    cnt = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      step();
    end
    chk("busy_len", cnt, 7 * 34 * CD);
    chk("ref_count", wq.size(), 7);
    chk_words("ref", 0);

    // Three requests mid-refresh coalesce into one more.
    wq.delete();
    digits = 24'h111111;
    dp     = 6'b000000;
    pulse_upd();
    repeat (40) step();
    for (int i = 0; i < 3; i++) begin
      pulse_upd();
      repeat (50) step();
    end
    digits = 24'h246802;
    dp     = 6'b100001;
    bri    = 4'h3;
    wait_idle();
    repeat (100) step();
    chk("coal_count", wq.size(), 14);
    chk1("coal_busy", busy, 1'b0);
    ex = '{16'h0A07, 16'h0101, 16'h0201, 16'h0301,
           16'h0401, 16'h0501, 16'h0601};
    chk_words("coal_a", 0);
    ex = '{16'h0A03, 16'h0182, 16'h0200, 16'h0308,
           16'h0406, 16'h0504, 16'h0682};
    chk_words("coal_b", 7);

    // Leading-zero handling.
    wq.delete();
    digits = 24'h000705;
    dp     = 6'b000000;
    bri    = 4'h7;
    pulse_upd();
    wait_idle();
`ifdef SERIAL_DISPLAY_LEADING_BLANK_EN
    ex = '{16'h0A07, 16'h0105, 16'h0200, 16'h0307,
           16'h040F, 16'h050F, 16'h060F};
`else
    ex = '{16'h0A07, 16'h0105, 16'h0200, 16'h0307,
           16'h0400, 16'h0500, 16'h0600};
`endif
    chk_words("blank", 0);

    // Reset mid-word restarts init.
    wq.delete();
    digits = 24'h654321;
    bri    = 4'h5;
    pulse_upd();
    repeat (20) step();
    chk1("mid_load_low", load, 1'b0);
    rst_n = 1'b0;
    step();
    chk1("mrst_load", load, 1'b1);
    chk1("mrst_sck", sck, 1'b0);
    chk1("mrst_dout", dout, 1'b0);
    chk1("mrst_busy", busy, 1'b1);
    chk("mrst_nowords", wq.size(), 0);
    wq.delete();
    gq.delete();
    step();
    rst_n = 1'b1;
    wait_words(7);
    ex = '{16'h0C01, 16'h0B05, 16'h09FF,
           16'h0A05, 16'h0F00};
    chk_words("reinit", 0);

    // Enable drop freezes after the word in flight.
    cnt = 0;
    while (load && cnt < 500) begin
      step();
      cnt++;
    end
    chk1("en_word_start", load, 1'b0);
    en = 1'b0;
    repeat (150) step();
    pulse_upd();
    repeat (150) step();
    chk("frz_count", wq.size(), 8);
    chk1("frz_load", load, 1'b1);
    chk1("frz_sck", sck, 1'b0);
    chk1("frz_busy", busy, 1'b1);
    en = 1'b1;
    wait_idle();
    chk("resume_count", wq.size(), 19);
    ex = '{16'h0A05, 16'h0101, 16'h0202, 16'h0303,
           16'h0404, 16'h0505, 16'h0606};
    chk_words("resume_a", 5);
    chk_words("resume_b", 12);

    chk("bus_phase_err", m_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
